// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Canonical RISC-V NOP (addi x0, x0, 0), presented when the queue is empty
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam int ALEN_DEFAULT  = 6;
    localparam int ILEN_DEFAULT  = 32;
    localparam int DEPTH_DEFAULT = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, pc} pairs. Flush empties it in one
// cycle; head outputs come straight from storage and read as NOP/0 when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int ALEN  = ALEN_DEFAULT,
    parameter int ILEN  = ILEN_DEFAULT,
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    push,
    input  logic [ILEN-1:0]         push_instr,
    input  logic [ALEN-1:0]         push_pc,
    input  logic                    pop,
    input  logic                    flush,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    head_valid,
    output logic [ILEN-1:0]         head_instr,
    output logic [ALEN-1:0]         head_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ILEN-1:0] instr_mem [DEPTH];
    logic [ALEN-1:0] pc_mem    [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    // Flush wins over everything; a push into a full queue is only legal alongside a pop
    always_comb begin
        do_pop  = pop && (count != '0) && !flush;
        do_push = push && !flush && ((count != CW'(DEPTH)) || do_pop);
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock) begin
        if (!reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents are qualified by count so they need no reset
    always_ff @(posedge clock) begin
        if (do_push) begin
            instr_mem[wr_ptr] <= push_instr;
            pc_mem[wr_ptr]    <= push_pc;
        end
    end

    // Head presentation, defaulting to NOP/0 when empty
    always_comb begin
        head_valid = (count != '0);
        head_instr = head_valid ? instr_mem[rd_ptr] : ILEN'(NOP_INSTR);
        head_pc    = head_valid ? pc_mem[rd_ptr]    : '0;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns the PC, issues credit-limited reads to a
// synchronous instruction memory and queues the returned words for decode.
// Optional activity counters are enabled by defining FETCH_QUEUE_STATS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int          ALEN     = ALEN_DEFAULT,
    parameter int          ILEN     = ILEN_DEFAULT,
    parameter int          DEPTH    = DEPTH_DEFAULT,
    parameter int unsigned RESET_PC = 0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            halt,
    input  logic            redirect_valid,
    input  logic [ALEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [ALEN-1:0] imem_addr,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [ALEN-1:0] instr_pc,
    input  logic            instr_ready
`ifdef FETCH_QUEUE_STATS_EN
    ,
    output logic [31:0]     stat_fetched,
    output logic [31:0]     stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t    state;
    fetch_state_t    next_state;
    logic [ALEN-1:0] pc;
    logic            rsp_vld_p1;
    logic [ALEN-1:0] rsp_pc_p1;
    logic [CW-1:0]   count;
    logic [CW-1:0]   credit;
    logic            push;
    logic            pop;

    // Queued plus outstanding entries; a read is only issued if it is
    // guaranteed a slot, ignoring any pop happening this cycle
    assign credit = count + CW'(rsp_vld_p1);

    // FSM state register
    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // FSM next-state logic; a redirect from any state (re)enters FLUSH
    always_comb begin
        next_state = state;
        if (redirect_valid) begin
            next_state = FLUSH;
        end else begin
            case (state)
                IDLE:    next_state = RUN;
                RUN:     if (halt) next_state = HALTED;
                FLUSH:   next_state = halt ? HALTED : RUN;
                HALTED:  if (!halt) next_state = RUN;
                default: next_state = IDLE;
            endcase
        end
    end

    // FSM outputs: issue only in RUN, never on a redirect cycle
    always_comb begin
        imem_req = 1'b0;
        if (state == RUN && !redirect_valid && credit < CW'(DEPTH)) imem_req = 1'b1;
    end

    assign imem_addr = pc;

    // PC and in-flight tracking; a redirect drops the outstanding response
    always_ff @(posedge clock) begin
        if (!reset) begin
            pc         <= ALEN'(RESET_PC);
            rsp_vld_p1 <= 1'b0;
        end else begin
            rsp_vld_p1 <= imem_req;
            if (redirect_valid)  pc <= redirect_pc;
            else if (imem_req)   pc <= pc + ALEN'(1);
        end
    end

    // ---- stage boundary: request -> response (memory returns one cycle later)
    always_ff @(posedge clock) begin
        if (imem_req) rsp_pc_p1 <= pc;
    end

    assign push = rsp_vld_p1 && !redirect_valid;
    assign pop  = instr_valid && instr_ready && !redirect_valid;

    // ---- stage boundary: response -> prefetch queue -> decode
    fetch_fifo #(
        .ALEN  (ALEN),
        .ILEN  (ILEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_instr (imem_rdata),
        .push_pc    (rsp_pc_p1),
        .pop        (pop),
        .flush      (redirect_valid),
        .count      (count),
        .head_valid (instr_valid),
        .head_instr (instr),
        .head_pc    (instr_pc)
    );

`ifdef FETCH_QUEUE_STATS_EN
    // Activity counters: delivered instructions and work discarded by redirects
    always_ff @(posedge clock) begin
        if (!reset) begin
            stat_fetched <= '0;
            stat_flushed <= '0;
        end else begin
            if (pop) stat_fetched <= stat_fetched + 32'd1;
            if (redirect_valid) stat_flushed <= stat_flushed + 32'(count) + 32'(rsp_vld_p1);
        end
    end
`endif

endmodule
